// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// exec_unit -- single-issue execute stage with registered writeback.
//
// Simple ALU ops (add/sub/and/or/xor/sll/srl) complete in one cycle.
// op_mul is an iterative shift-add multiply: one step per cycle for DATA_W
// cycles, returning the low DATA_W bits of the product.
//
// Optional feature macro: EXEC_MUL_EN
//   defined   : MUL state, step counter and multiply datapath are built.
//   undefined : op_mul is treated exactly like op_none; busy_o is tied to 0.
//
// fur_sig_i field layout (MSB -> LSB), total DATA_W+REG_AW+6 bits:
//   [DATA_W+REG_AW+5]                 alu_s1_font (1 = operand B is imm)
//   [DATA_W+REG_AW+4 : DATA_W+REG_AW+1] alu_opcode (4 bits)
//   [DATA_W+REG_AW]                   wb_wr
//   [DATA_W+REG_AW-1 : DATA_W]         reg_dst
//   [DATA_W-1 : 0]                     imm
// Opcode encoding: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl,
//                  8 mul, others behave as none.
//
// Ports:
//   clk          rising-edge clock
//   arstn        synchronous active-low reset
//   op_a_i       register operand 1
//   op_b_i       register operand 2
//   fur_sig_i    registered control bundle (layout above)
//   busy_o       stall request: the instruction presented next cycle is not
//                accepted while this is high
//   wb_valid_o   single-cycle writeback strobe
//   wb_data_o    writeback data
//   wb_addr_o    writeback register address
//   zero_o       wb_data_o == 0, registered alongside wb_data_o
//   dbg_state_o  FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: an instruction is accepted in any cycle the FSM is in IDLE.
// While in MUL every input is ignored; upstream must hold off using busy_o.
// ---------------------------------------------------------------------------
module exec_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [DATA_W-1:0]          op_a_i,
  input  logic [DATA_W-1:0]          op_b_i,
  input  logic [DATA_W+REG_AW+5:0]   fur_sig_i,
  output logic                       busy_o,
  output logic                       wb_valid_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [REG_AW-1:0]          wb_addr_o,
  output logic                       zero_o,
  output logic                       dbg_state_o
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  // Control field decode
  logic [DATA_W-1:0] imm;
  logic [REG_AW-1:0] reg_dst;
  logic              wb_wr;
  logic [3:0]        opcode;
  logic              s1_font;

  assign imm     = fur_sig_i[DATA_W-1:0];
  assign reg_dst = fur_sig_i[DATA_W +: REG_AW];
  assign wb_wr   = fur_sig_i[DATA_W+REG_AW];
  assign opcode  = fur_sig_i[DATA_W+REG_AW+1 +: 4];
  assign s1_font = fur_sig_i[DATA_W+REG_AW+5];

  logic [DATA_W-1:0] opnd_b;
  assign opnd_b = s1_font ? imm : op_b_i;

  logic is_alu;
  assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_SRL);

  // Single-cycle ALU
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = op_a_i + opnd_b;
      OP_SUB:  alu_res = op_a_i - opnd_b;
      OP_AND:  alu_res = op_a_i & opnd_b;
      OP_OR:   alu_res = op_a_i | opnd_b;
      OP_XOR:  alu_res = op_a_i ^ opnd_b;
      OP_SLL:  alu_res = op_a_i << opnd_b[SH_W-1:0];
      OP_SRL:  alu_res = op_a_i >> opnd_b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  state_t state_q;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W-1);

  state_t            state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [REG_AW-1:0] mul_dst_q, mul_dst_d;
  logic              mul_wr_q, mul_wr_d;
  logic              is_mul;
  logic              mul_last;
  logic [DATA_W-1:0] mul_res;

  assign is_mul   = (opcode == OP_MUL);
  assign mul_last = (cnt_q == CNT_LAST);
  // Accumulator after this cycle's step: A is pre-shifted, B consumed LSB first.
  assign mul_res  = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  // State register
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      mul_dst_q <= '0;
      mul_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      mul_dst_q <= mul_dst_d;
      mul_wr_q  <= mul_wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    mul_dst_d = mul_dst_q;
    mul_wr_d  = mul_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mul) begin
          state_d   = ST_MUL;
          cnt_d     = '0;
          mul_a_d   = op_a_i;
          mul_b_d   = opnd_b;
          acc_d     = '0;
          mul_dst_d = reg_dst;
          mul_wr_d  = wb_wr;
        end
      end
      ST_MUL: begin
        acc_d   = mul_res;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        if (mul_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: stall while a multiply is being accepted or still has
  // more than its final step to run.
  always_comb begin
    busy_o = 1'b0;
    if (arstn) begin
      case (state_q)
        ST_IDLE: busy_o = is_mul;
        ST_MUL:  busy_o = !mul_last;
        default: busy_o = 1'b0;
      endcase
    end
  end
`else
  assign state_q = ST_IDLE;
  assign busy_o  = 1'b0;
`endif

  // Writeback registers
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic              zero_q, zero_d;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    zero_d     = zero_q;
    if ((state_q == ST_IDLE) && is_alu) begin
      wb_valid_d = wb_wr;
      wb_data_d  = alu_res;
      wb_addr_d  = reg_dst;
      zero_d     = (alu_res == '0);
    end
`ifdef EXEC_MUL_EN
    else if ((state_q == ST_MUL) && mul_last) begin
      wb_valid_d = mul_wr_q;
      wb_data_d  = mul_res;
      wb_addr_d  = mul_dst_q;
      zero_d     = (mul_res == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      zero_q     <= 1'b1;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      zero_q     <= zero_d;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_data_o   = wb_data_q;
  assign wb_addr_o   = wb_addr_q;
  assign zero_o      = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_unit -- directed bench for exec_unit (DATA_W=32, REG_AW=5).
// Inputs change 1 time unit after a rising edge ("cycle N" = the interval
// after the Nth edge); outputs are sampled on the falling edge of a cycle.
// Multiply checks are compiled only when EXEC_MUL_EN is defined; otherwise
// the bench checks that op_mul behaves like op_none.
// ---------------------------------------------------------------------------
module tb_exec_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FW = DW + AW + 6;

  localparam logic [3:0] NONE = 4'd0;
  localparam logic [3:0] ADD  = 4'd1;
  localparam logic [3:0] SUB  = 4'd2;
  localparam logic [3:0] AND_ = 4'd3;
  localparam logic [3:0] OR_  = 4'd4;
  localparam logic [3:0] XOR_ = 4'd5;
  localparam logic [3:0] SLL  = 4'd6;
  localparam logic [3:0] SRL  = 4'd7;
  localparam logic [3:0] MUL  = 4'd8;

  // clock / reset
  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic [DW-1:0] op_a, op_b;
  logic [FW-1:0] fur;
  logic          busy, wb_valid, zero, dbg_state;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;

  exec_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .fur_sig_i  (fur),
    .busy_o     (busy),
    .wb_valid_o (wb_valid),
    .wb_data_o  (wb_data),
    .wb_addr_o  (wb_addr),
    .zero_o     (zero),
    .dbg_state_o(dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [FW-1:0] pk(input logic font, input logic [3:0] opc,
                                       input logic wr, input logic [AW-1:0] dst,
                                       input logic [DW-1:0] imm);
    return {font, opc, wr, dst, imm};
  endfunction

  // driver: start a new cycle with the given inputs
  task automatic cyc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [FW-1:0] f);
    @(posedge clk);
    #1;
    op_a = a;
    op_b = b;
    fur  = f;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic seen_valid;

  initial begin
    arstn = 1'b0;
    op_a  = '0;
    op_b  = '0;
    fur   = '0;

    // Reset, with an op_mul presented so busy must be forced low
    cyc(32'd3, 32'd3, pk(1'b0, MUL, 1'b1, 5'd2, 32'd0));
    @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_data",  wb_data, 0);
    chk("rst_addr",  wb_addr, 0);
    chk("rst_zero",  zero, 1);
    chk("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    fur   = pk(1'b0, NONE, 1'b0, 5'd0, 32'd0);

    // add 5+7 -> r3
    cyc(32'd5, 32'd7, pk(1'b0, ADD, 1'b1, 5'd3, 32'd0));
    @(negedge clk);
    chk("add_busy", busy, 0);
    cyc(32'd10, 32'd0, pk(1'b1, SUB, 1'b1, 5'd1, 32'd10)); // sub with imm
    @(negedge clk);
    chk("add_valid", wb_valid, 1);
    chk("add_data",  wb_data, 12);
    chk("add_addr",  wb_addr, 3);
    chk("add_zero",  zero, 0);
    cyc(32'd1, 32'd33, pk(1'b0, SLL, 1'b1, 5'd2, 32'd0));  // shift amount 33 mod 32 = 1
    @(negedge clk);
    chk("sub_valid", wb_valid, 1);
    chk("sub_data",  wb_data, 0);
    chk("sub_addr",  wb_addr, 1);
    chk("sub_zero",  zero, 1);
    cyc(32'hF0, 32'h0F, pk(1'b0, OR_, 1'b1, 5'd0, 32'd0));
    @(negedge clk);
    chk("sll_data", wb_data, 2);
    chk("sll_zero", zero, 0);
    cyc(32'hFF, 32'h0F, pk(1'b0, XOR_, 1'b1, 5'd31, 32'd0));
    @(negedge clk);
    chk("or_data",  wb_data, 32'hFF);
    chk("or_addr0", wb_addr, 0);
    cyc(32'h8000_0000, 32'd31, pk(1'b0, SRL, 1'b1, 5'd6, 32'd0));
    @(negedge clk);
    chk("xor_data", wb_data, 32'hF0);
    chk("xor_addr", wb_addr, 31);
    cyc(32'hFFFF_FFFF, 32'd2, pk(1'b0, ADD, 1'b1, 5'd7, 32'd0));
    @(negedge clk);
    chk("srl_data", wb_data, 1);
    cyc(32'd0, 32'd1, pk(1'b0, SUB, 1'b1, 5'd8, 32'd0));
    @(negedge clk);
    chk("addwrap_data", wb_data, 1);
    cyc(32'h1234, 32'h5678, pk(1'b0, NONE, 1'b1, 5'd9, 32'd0));
    @(negedge clk);
    chk("subwrap_data", wb_data, 32'hFFFF_FFFF);
    chk("subwrap_zero", zero, 0);

    // op_none: no strobe, previous result held
    cyc(32'hFF, 32'h0F, pk(1'b0, AND_, 1'b0, 5'd4, 32'd0));
    @(negedge clk);
    chk("none_valid", wb_valid, 0);
    chk("none_data",  wb_data, 32'hFFFF_FFFF);
    chk("none_addr",  wb_addr, 8);

    // and with wb_wr=0: never a strobe
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
      @(negedge clk);
      seen_valid = seen_valid | wb_valid;
    end
    chk("and_nowr_valid", seen_valid, 0);

`ifdef EXEC_MUL_EN
    // 6*7 -> r4, adds presented while busy must be ignored
    cyc(32'd6, 32'd7, pk(1'b0, MUL, 1'b1, 5'd4, 32'd0));
    @(negedge clk);
    chk("mul_busy_c0", busy, 1);
    seen_valid = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      cyc(32'd1, 32'd1, pk(1'b0, ADD, 1'b1, 5'd9, 32'd0));
      @(negedge clk);
      if (busy !== 1'b1) chk($sformatf("mul_busy_c%0d", c), busy, 1);
      seen_valid = seen_valid | wb_valid;
    end
    chk("mul_busy_mid", busy, 1);
    chk("mul_state_mid", dbg_state, 1);
    cyc(32'd1, 32'd1, pk(1'b0, ADD, 1'b1, 5'd9, 32'd0));
    @(negedge clk);
    chk("mul_busy_c32", busy, 0);
    seen_valid = seen_valid | wb_valid;
    chk("mul_no_early_valid", seen_valid, 0);
    cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
    @(negedge clk);
    chk("mul_valid_c33", wb_valid, 1);
    chk("mul_data",  wb_data, 42);
    chk("mul_addr",  wb_addr, 4);
    chk("mul_zero",  zero, 0);
    chk("mul_state_idle", dbg_state, 0);
    cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
    @(negedge clk);
    chk("mul_valid_pulse", wb_valid, 0);

    // product whose low 32 bits are zero, operand B from imm
    cyc(32'h0001_0000, 32'd0, pk(1'b1, MUL, 1'b1, 5'd5, 32'h0001_0000));
    for (int c = 1; c <= 33; c++) begin
      cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
    end
    @(negedge clk);
    chk("mul2_valid", wb_valid, 1);
    chk("mul2_data",  wb_data, 0);
    chk("mul2_zero",  zero, 1);
    chk("mul2_addr",  wb_addr, 5);

    // reset in cycle 10 of a multiply aborts it
    cyc(32'd9, 32'd9, pk(1'b0, MUL, 1'b1, 5'd6, 32'd0));
    for (int c = 1; c <= 9; c++) begin
      cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
    end
    @(posedge clk);
    #1;
    arstn = 1'b0;
    @(negedge clk);
    chk("abort_busy_rst", busy, 0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    @(negedge clk);
    chk("abort_state", dbg_state, 0);
    chk("abort_busy",  busy, 0);
    seen_valid = wb_valid;
    for (int c = 0; c < 40; c++) begin
      cyc(32'd0, 32'd0, pk(1'b0, NONE, 1'b0, 5'd0, 32'd0));
      @(negedge clk);
      seen_valid = seen_valid | wb_valid;
    end
    chk("abort_no_valid", seen_valid, 0);
`else
    // without the multiplier op_mul is a no-op
    cyc(32'd3, 32'd3, pk(1'b0, MUL, 1'b1, 5'd2, 32'd0));
    @(negedge clk);
    chk("nomul_busy", busy, 0);
    seen_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(32'd3, 32'd3, pk(1'b0, MUL, 1'b1, 5'd2, 32'd0));
      @(negedge clk);
      seen_valid = seen_valid | wb_valid | busy;
    end
    chk("nomul_no_valid", seen_valid, 0);
    chk("nomul_state", dbg_state, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; equals the imm_t width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width; equals the reg_t width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port arstn  in  1  synchronous active-low reset.
REQ-006 SHALL have port op_a_i  in  DATA_W  register operand 1, from the register stage data_out1.
REQ-007 SHALL have port op_b_i  in  DATA_W  register operand 2, from the register stage data_out2.
REQ-008 SHALL have port fur_sig_i  in  reg_fur_sig_t  registered alu_s1_font, alu_opcode, wb_wr, reg_dst, imm.
REQ-009 SHALL have port busy_o  out  1  stall request to upstream control; instruction not accepted next cycle.
REQ-010 SHALL have port wb_valid_o  out  1  writeback strobe to the register bank.
REQ-011 SHALL have port wb_data_o  out  DATA_W  writeback data.
REQ-012 SHALL have port wb_addr_o  out  REG_AW  writeback register address.
REQ-013 SHALL have port zero_o  out  1  result-equals-zero flag, qualified by wb_valid_o.

Function
REQ-014 Operand A SHALL be op_a_i; operand B SHALL be imm when alu_s1_font=1, else op_b_i.
REQ-015 Opcodes SHALL map as: op_add A+B, op_sub A-B, op_and, op_or, op_xor bitwise, op_sll A<<B[log2(DATA_W)-1:0], op_srl logical right shift by the same amount, op_mul low DATA_W bits of A*B.
REQ-016 Add/sub SHALL wrap modulo 2^DATA_W; no carry or overflow output.
REQ-017 op_none SHALL produce no writeback and leave state unchanged.
REQ-018 State machine SHALL have two states: IDLE and MUL.
REQ-019 In IDLE, a non-mul op SHALL be accepted; registered result appears next cycle with wb_valid_o = wb_wr and wb_addr_o = reg_dst. Latency is 1.
REQ-020 In IDLE, op_mul SHALL latch A, B, reg_dst, wb_wr; move to MUL with counter 0.
REQ-021 MUL SHALL perform one shift-add step per cycle; counter increments each cycle; after the step at counter=DATA_W-1, return to IDLE.
REQ-022 The mul result SHALL drive wb_valid_o (if latched wb_wr=1) in the cycle after the last MUL cycle. Latency is DATA_W+1 cycles from acceptance.
REQ-023 busy_o SHALL be combinational: (IDLE and incoming op_mul) or (MUL and counter != DATA_W-1).
REQ-024 Inputs presented while in MUL SHALL be ignored; upstream inserts bubbles.
REQ-025 wb_valid_o SHALL be a single-cycle pulse per accepted instruction with wb_wr=1; it stays 0 when wb_wr=0.
REQ-026 Destination register 0 SHALL have no special treatment.
REQ-027 Data hazards on a pending result SHALL be the responsibility of upstream control; there is no bypass.
REQ-028 zero_o SHALL be registered with wb_data_o and SHALL equal (wb_data_o==0).

Reset
REQ-029 While arstn=0 at a clock edge: state IDLE, counter 0, wb_valid_o=0, wb_data_o=0, wb_addr_o=0, zero_o=1.
REQ-030 busy_o SHALL be forced 0 while arstn=0.
REQ-031 Reset during MUL SHALL abort the multiply; no writeback occurs for it.

Configuration
REQ-032 Macro EXEC_MUL_EN SHALL, when defined, compile in the MUL state, counter and multiply datapath.
REQ-033 Without EXEC_MUL_EN, op_mul SHALL behave as op_none (no writeback) and busy_o SHALL be constant 0.

Verification
REQ-034 a=5, b=7, op_add, wb_wr=1, dst=3 -> next cycle wb_valid=1, data=12, addr=3, zero=0.
REQ-035 a=10, imm=10, font=1, op_sub, dst=1 -> next cycle data=0, zero=1; then a=1, b=33, op_sll -> data=2.
REQ-036 op_and with wb_wr=0 -> wb_valid stays 0 for all cycles.
REQ-037 EXEC_MUL_EN, DATA_W=32, a=6, b=7, op_mul, dst=4 accepted in cycle 0, op_add in cycles 1-31 -> busy=1 cycles 0-31, busy=0 cycle 32, single wb_valid in cycle 33 with data=42, addr=4, adds ignored.
REQ-038 Mul accepted cycle 0, arstn=0 in cycle 10 -> cycle 11 IDLE, busy=0, wb_valid never asserted for that mul.
REQ-039 Without EXEC_MUL_EN, op_mul a=3, b=3, wb_wr=1 -> busy=0, wb_valid=0 always.
